// File: rtl/afe_attn_spi_sequencer.sv
// AFE attenuator SPI sequencer: shifts one word MSB-first into the
// selected bus, then pulses that bus's latch enable.
module afe_attn_spi_sequencer #(
   parameter int CHANNEL_COUNT     = 2,
   parameter int CHANNEL_SEL_WIDTH = 1,
   parameter int DATA_WIDTH        = 8,
   parameter int CLK_DIV           = 25,
   parameter int LE_HALF_PERIODS   = 2
) (
   input  logic                         sysClk,
   input  logic                         sysReset_n,
   input  logic                         wrStrobe,
   input  logic [CHANNEL_SEL_WIDTH-1:0] wrChannel,
   input  logic [DATA_WIDTH-1:0]        wrData,
   input  logic                         clrRejected,
   output logic                         busy,
   output logic                         done,
   output logic                         rejected,
   output logic [CHANNEL_COUNT-1:0]     spiClk,
   output logic [CHANNEL_COUNT-1:0]     spiSdi,
   output logic [CHANNEL_COUNT-1:0]     spiLe
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int LW = (LE_HALF_PERIODS > 1) ? $clog2(LE_HALF_PERIODS) : 1;
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int SW = CHANNEL_SEL_WIDTH;

   localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
   localparam logic [LW-1:0] LE_M1  = LW'(LE_HALF_PERIODS - 1);
   localparam logic [BW-1:0] NBITS  = BW'(DATA_WIDTH);
   localparam logic [SW:0]   CH_LIM = (SW+1)'(CHANNEL_COUNT);

   typedef enum logic [2:0] {
      IDLE, SETUP, HIGH, GAP, LATCH
   } state_t;

   state_t state, state_n;

   logic [CW-1:0]            cnt, cnt_n;
   logic [LW-1:0]            le_cnt, le_cnt_n;
   logic [BW-1:0]            bits, bits_n;
   logic [DATA_WIDTH-1:0]    sr, sr_n;
   logic [SW-1:0]            ch, ch_n;
   logic                     ch_ok, expired;
   logic                     busy_n, done_n, rej_n;
   logic [CHANNEL_COUNT-1:0] clk_n, sdi_n, le_n;

   assign ch_ok   = ({1'b0, wrChannel} < CH_LIM);
   assign expired = (cnt == '0);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      le_cnt_n = le_cnt;
      bits_n   = bits;
      sr_n     = sr;
      ch_n     = ch;
      done_n   = 1'b0;
      rej_n    = rejected;

      if (state != IDLE)
         cnt_n = cnt - CW'(1);

      unique case (state)
         IDLE: begin
            if (wrStrobe && ch_ok) begin
               sr_n    = wrData;
               ch_n    = wrChannel;
               bits_n  = NBITS;
               cnt_n   = DIV_M1;
               state_n = SETUP;
            end
         end
         SETUP: begin
            if (expired) begin
               cnt_n   = DIV_M1;
               state_n = HIGH;
            end
         end
         HIGH: begin
            if (expired) begin
               cnt_n  = DIV_M1;
               bits_n = bits - BW'(1);
               if (bits == BW'(1)) begin
                  state_n = GAP;
               end else begin
                  sr_n    = sr << 1;
                  state_n = SETUP;
               end
            end
         end
         GAP: begin
            if (expired) begin
               cnt_n    = DIV_M1;
               le_cnt_n = LE_M1;
               state_n  = LATCH;
            end
         end
         LATCH: begin
            // LE spans several half periods; count them separately
            if (expired) begin
               cnt_n = DIV_M1;
               if (le_cnt == '0) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end else begin
                  le_cnt_n = le_cnt - LW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (clrRejected)
         rej_n = 1'b0;
      if (wrStrobe && (state != IDLE || !ch_ok))
         rej_n = 1'b1;

      busy_n = (state_n != IDLE);
      clk_n  = '0;
      sdi_n  = '0;
      le_n   = '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
         if (ch_n == i[SW-1:0]) begin
            clk_n[i] = (state_n == HIGH);
            sdi_n[i] = (state_n == SETUP || state_n == HIGH ||
                        state_n == GAP) && sr_n[DATA_WIDTH-1];
            le_n[i]  = (state_n == LATCH);
         end
      end
   end

   always_ff @(posedge sysClk or negedge sysReset_n) begin
      if (!sysReset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         le_cnt   <= '0;
         bits     <= '0;
         sr       <= '0;
         ch       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rejected <= 1'b0;
         spiClk   <= '0;
         spiSdi   <= '0;
         spiLe    <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         le_cnt   <= le_cnt_n;
         bits     <= bits_n;
         sr       <= sr_n;
         ch       <= ch_n;
         busy     <= busy_n;
         done     <= done_n;
         rejected <= rej_n;
         spiClk   <= clk_n;
         spiSdi   <= sdi_n;
         spiLe    <= le_n;
      end
   end

endmodule

// File: tb/tb_afe_attn_spi_sequencer.sv
// Bench for afe_attn_spi_sequencer: table-driven transfers plus
// hand-written collision, invalid-channel, back-to-back and reset cases.
module tb_afe_attn_spi_sequencer;

   localparam int DIV = 2;
   localparam int LEH = 1;
   localparam int LEN = (2*8 + 1 + LEH) * DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_strobe = 1'b0;
   logic [0:0] wr_ch = '0;
   logic [7:0] wr_data = '0;
   logic       clr_rej = 1'b0;
   logic       busy, done, rejected;
   logic [1:0] spi_clk, spi_sdi, spi_le;

   logic       wr_strobe3 = 1'b0;
   logic [1:0] wr_ch3 = '0;
   logic       busy3, done3, rejected3;
   logic [2:0] spi_clk3, spi_sdi3, spi_le3;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   afe_attn_spi_sequencer #(
      .CHANNEL_COUNT(2), .CHANNEL_SEL_WIDTH(1), .DATA_WIDTH(8),
      .CLK_DIV(DIV), .LE_HALF_PERIODS(LEH)
   ) u_dut (
      .sysClk(clk), .sysReset_n(rst_n), .wrStrobe(wr_strobe),
      .wrChannel(wr_ch), .wrData(wr_data), .clrRejected(clr_rej),
      .busy(busy), .done(done), .rejected(rejected),
      .spiClk(spi_clk), .spiSdi(spi_sdi), .spiLe(spi_le)
   );

   afe_attn_spi_sequencer #(
      .CHANNEL_COUNT(3), .CHANNEL_SEL_WIDTH(2), .DATA_WIDTH(8),
      .CLK_DIV(DIV), .LE_HALF_PERIODS(LEH)
   ) u_dut3 (
      .sysClk(clk), .sysReset_n(rst_n), .wrStrobe(wr_strobe3),
      .wrChannel(wr_ch3), .wrData(wr_data), .clrRejected(clr_rej),
      .busy(busy3), .done(done3), .rejected(rejected3),
      .spiClk(spi_clk3), .spiSdi(spi_sdi3), .spiLe(spi_le3)
   );

   typedef struct {
      logic [7:0] data;
      int         ch;
      int         coll;
      logic [7:0] exp_word;
      int         exp_done;
      int         exp_le;
      int         exp_rej;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a write and observe bus activity until done (bounded).
   task automatic xfer(input logic [7:0] d, input int c, input int coll,
                       output logic [7:0] word, output int nbits,
                       output int le_cyc, output int done_at,
                       output int glitch, output int rej_at);
      logic prev;
      int   oc;
      oc = 1 - c;
      step();
      wr_data = d;
      wr_ch = c[0:0];
      wr_strobe = 1'b1;
      step();
      wr_strobe = 1'b0;
      word = '0; nbits = 0; le_cyc = 0;
      done_at = -1; glitch = 0; rej_at = -1; prev = 1'b0;
      for (int n = 1; n <= 80 && done_at < 0; n++) begin
         if (n == 1) begin
            chk("busy_t1", busy, 1);
            chk("sdi_t1", spi_sdi[c], d[7]);
         end
         if (spi_clk[c] && !prev) begin
            word = {word[6:0], spi_sdi[c]};
            nbits++;
         end
         prev = spi_clk[c];
         if (spi_le[c]) le_cyc++;
         if (spi_le[c] && (spi_sdi[c] || spi_clk[c])) glitch++;
         if (spi_clk[oc] || spi_sdi[oc] || spi_le[oc]) glitch++;
         if (done) done_at = n;
         if (rejected && rej_at < 0) rej_at = n;
         if (n == coll) begin
            wr_data = 8'hFF;
            wr_strobe = 1'b1;
         end else begin
            wr_strobe = 1'b0;
         end
         step();
      end
      wr_strobe = 1'b0;
   endtask

   task automatic clear_rej();
      clr_rej = 1'b1;
      step();
      clr_rej = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] word;
      int nbits, le_cyc, done_at, glitch, rej_at, cnt;

      vecs[0] = '{8'hA5, 0, 0, 8'hA5, LEN + 1, LEH * DIV, -1};
      vecs[1] = '{8'h3C, 1, 0, 8'h3C, LEN + 1, LEH * DIV, -1};
      vecs[2] = '{8'h11, 0, 5, 8'h11, LEN + 1, LEH * DIV, 6};
      vecs[3] = '{8'h80, 0, 0, 8'h80, LEN + 1, LEH * DIV, -1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rej", rejected, 0);
      chk("rst_bus", {spi_clk, spi_sdi, spi_le}, 0);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         xfer(vecs[i].data, vecs[i].ch, vecs[i].coll,
              word, nbits, le_cyc, done_at, glitch, rej_at);
         chk($sformatf("v%0d_word", i), word, vecs[i].exp_word);
         chk($sformatf("v%0d_nbits", i), nbits, 8);
         chk($sformatf("v%0d_le", i), le_cyc, vecs[i].exp_le);
         chk($sformatf("v%0d_done", i), done_at, vecs[i].exp_done);
         chk($sformatf("v%0d_glitch", i), glitch, 0);
         chk($sformatf("v%0d_rej", i), rej_at, vecs[i].exp_rej);
         chk($sformatf("v%0d_idle", i), busy, 0);
         if (rejected) begin
            clear_rej();
            chk($sformatf("v%0d_clr", i), rejected, 0);
         end
      end

      // clear and reject in the same cycle: set wins
      wr_data = 8'h42; wr_ch = 1'b0; wr_strobe = 1'b1;
      step();
      wr_strobe = 1'b0;
      step();
      clr_rej = 1'b1; wr_strobe = 1'b1; wr_data = 8'hFF;
      step();
      clr_rej = 1'b0; wr_strobe = 1'b0;
      chk("clr_vs_set", rejected, 1);
      cnt = 0;
      while (!done && cnt < 80) begin step(); cnt++; end
      chk("clr_vs_set_done", done, 1);
      clear_rej();
      chk("clr_only", rejected, 0);

      // invalid channel on the three-bus instance
      wr_ch3 = 2'd3; wr_strobe3 = 1'b1;
      step();
      wr_strobe3 = 1'b0;
      glitch = 0;
      for (int n = 0; n < 10; n++) begin
         if (busy3 || spi_clk3 != 0 || spi_sdi3 != 0 || spi_le3 != 0)
            glitch++;
         step();
      end
      chk("inv_quiet", glitch, 0);
      chk("inv_rej", rejected3, 1);

      // back-to-back: second strobe in the done cycle
      wr_data = 8'h80; wr_ch = 1'b0; wr_strobe = 1'b1;
      step();
      wr_strobe = 1'b0;
      cnt = 0;
      while (!done && cnt < 80) begin step(); cnt++; end
      chk("b2b_done1", done, 1);
      chk("b2b_busy_low", busy, 0);
      wr_data = 8'h7E; wr_strobe = 1'b1;
      step();
      wr_strobe = 1'b0;
      chk("b2b_busy2", busy, 1);
      chk("b2b_sdi2", spi_sdi[0], 0);
      cnt = 1;
      while (!done && cnt < 80) begin step(); cnt++; end
      chk("b2b_done2", cnt, LEN + 1);
      chk("b2b_rej", rejected, 0);

      // reset during bit 3 high phase
      wr_data = 8'hFF; wr_ch = 1'b0; wr_strobe = 1'b1;
      step();
      wr_strobe = 1'b0;
      repeat ((2*3 + 1) * DIV) step();
      chk("rst_mid_high", {spi_clk[0], spi_sdi[0]}, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_bus", {spi_clk, spi_sdi, spi_le}, 0);
      chk("rst_mid_busy", busy, 0);
      repeat (2) step();
      rst_n = 1'b1;
      glitch = 0;
      for (int n = 0; n < 40; n++) begin
         if (spi_le != 0 || busy) glitch++;
         step();
      end
      chk("rst_no_le", glitch, 0);
      xfer(8'h5A, 0, 0, word, nbits, le_cyc, done_at, glitch, rej_at);
      chk("post_rst_word", word, 8'h5A);
      chk("post_rst_done", done_at, LEN + 1);
      chk("post_rst_le", le_cyc, LEH * DIV);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/afe_attn_spi_sequencer.md
# afe_attn_spi_sequencer

Serial sequencer that drives the AFE attenuator shift registers on the DSBPM board's `AFE_SPI_CLK`/`AFE_SPI_SDI`/`AFE_SPI_LE` pins.
- Accepts one attenuator word per software write in the `sysClk` domain.
- Shifts the word MSB-first into the selected AFE channel, then pulses that channel's latch enable.
- Sits directly upstream of the top-level AFE SPI outputs; its outputs go straight to the pads.

## Interface
- `CHANNEL_COUNT`, 2, number of independent AFE SPI buses (one CLK/SDI/LE triple each).
- `CHANNEL_SEL_WIDTH`, 1, width of channel selector; must satisfy 2^`CHANNEL_SEL_WIDTH` >= `CHANNEL_COUNT`.
- `DATA_WIDTH`, 8, bits shifted per transaction.
- `CLK_DIV`, 25, `sysClk` cycles per SCLK half period (100 MHz -> 2 MHz SCLK); minimum 1.
- `LE_HALF_PERIODS`, 2, LE pulse width in SCLK half periods; minimum 1.

Ports:
- `sysClk` input 1 — sole clock.
- `sysReset_n` input 1 — asynchronous, active-low reset.
- `wrStrobe` input 1 — single-cycle write request.
- `wrChannel` input `CHANNEL_SEL_WIDTH` — target bus, sampled with `wrStrobe`.
- `wrData` input `DATA_WIDTH` — word to shift, sampled with `wrStrobe`.
- `clrRejected` input 1 — clears the sticky `rejected` flag.
- `busy` output 1 — transaction in progress.
- `done` output 1 — one-cycle pulse at completion.
- `rejected` output 1 — sticky flag: a write was dropped.
- `spiClk` output `CHANNEL_COUNT` — SCLK per bus.
- `spiSdi` output `CHANNEL_COUNT` — data per bus.
- `spiLe` output `CHANNEL_COUNT` — latch enable per bus.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Non-selected buses hold `spiClk`/`spiSdi`/`spiLe` at 0 at all times.
- FSM states: IDLE, SETUP, HIGH, GAP, LATCH. A half-period counter reloads to `CLK_DIV`-1 on every state entry.

IDLE:
- All bus outputs are 0.
- Accept condition: `wrStrobe` with `wrChannel` < `CHANNEL_COUNT`.
- On accept: latch data into the shift register, latch the channel, set bit counter to `DATA_WIDTH`, go to SETUP.
- `wrStrobe` with out-of-range `wrChannel`: write is ignored and `rejected` is set.

SETUP (SCLK low):
- `spiSdi`[ch] = current MSB of the shift register.
- Hold for `CLK_DIV` cycles, then go to HIGH.

HIGH:
- `spiClk`[ch] = 1; SDI is unchanged. The slave samples on the rising edge.
- After `CLK_DIV` cycles, decrement the bit counter.
- If the counter is now 0, go to GAP. Otherwise shift left one bit and go to SETUP.

GAP:
- SCLK low, SDI holds the last bit.
- Hold for `CLK_DIV` cycles, then go to LATCH.

LATCH:
- `spiLe`[ch] = 1 and `spiSdi`[ch] = 0.
- Hold for `LE_HALF_PERIODS`·`CLK_DIV` cycles, then go to IDLE and assert `done`.

Status and edge cases:
- `busy` = 1 whenever the state is not IDLE.
- `wrStrobe` while `busy`: write is ignored and `rejected` is set. The transaction in flight is unaffected.
- `rejected` is cleared by `clrRejected`. If a rejection and `clrRejected` occur in the same cycle, the set wins.
- `wrStrobe` in the cycle `done` is high is accepted, since the FSM is already in IDLE.
- Reset asserted mid-transaction: outputs go to 0 immediately (asynchronously), the FSM returns to IDLE and the shifted word is discarded. No LE pulse is issued.

## Timing
- Let T = cycle in which `wrStrobe` is accepted.
- Cycle T+1: `busy` = 1 and SDI = bit `DATA_WIDTH`-1.
- Bit k (k = 0 first, MSB): SCLK rises at T+1+(2k+1)·`CLK_DIV`.
- The transaction occupies L = (2·`DATA_WIDTH` + 1 + `LE_HALF_PERIODS`)·`CLK_DIV` cycles: T+1 … T+L.
- LE is high for the final `LE_HALF_PERIODS`·`CLK_DIV` of those cycles.
- Cycle T+L+1: `done` = 1 and `busy` = 0.
- Defaults: L = 475, giving 4.75 µs per word at 100 MHz.
- Setup and hold of SDI around each SCLK rising edge is `CLK_DIV` cycles.
- `rejected` rises in the cycle after the offending strobe.

## Test plan
- **Single write.** `CLK_DIV`=2, `LE_HALF_PERIODS`=1, write 0xA5 to ch0.
  - Rising-edge samples of `spiSdi`[0] = 1,0,1,0,0,1,0,1.
  - LE high for 2 cycles; `done` at T+37.
  - ch1 stays 0.
- **Channel routing.** Write 0x3C to ch1.
  - Only bus 1 toggles; decoded word = 0x3C.
  - `rejected` stays 0.
- **Collision.** Strobe 0x11 on ch0, then strobe 0xFF at T+5.
  - Only 0x11 is shifted out.
  - `rejected` = 1 from T+6.
  - `clrRejected` pulse clears it; a clear and a new reject in the same cycle leaves it at 1.
- **Invalid channel.** `CHANNEL_COUNT`=3, `CHANNEL_SEL_WIDTH`=2, strobe with `wrChannel`=3.
  - No bus activity, `busy` stays 0, `rejected` = 1.
- **Back-to-back writes.** Strobe 0x80 on ch0, then a second strobe in the `done` cycle.
  - Second word is accepted.
  - `busy` is low for exactly that one cycle; `rejected` stays 0.
- **Reset mid-transfer.** Assert `sysReset_n`=0 during bit 3.
  - All outputs are 0 within the same cycle (asynchronous).
  - No LE pulse.
  - After release, a fresh write of 0x5A completes normally.
